// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Packages : global_types, control_signals
// Shared word typedefs plus the operation and FSM state enums of muldiv_unit.
// Rev      : 1.0  initial release
// ============================================================================

package global_types;
    typedef logic [31:0] logic32;
    typedef logic [63:0] logic64;
endpackage

package control_signals;
    typedef enum logic {
        MD_MULTU = 1'b0,
        MD_DIVU  = 1'b1
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } muldiv_state_t;
endpackage

`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : muldiv_unit_if
// Issue/result bundle between the execute stage and the multiply/divide unit.
// Rev       : 1.0  initial release
// ============================================================================

interface muldiv_unit_if
    import control_signals::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mf_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, a, b, mf_req,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, a, b, mf_req,
        output hi, lo, busy, done, stall
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit_divu_step.sv
`default_nettype none
// ============================================================================
// Module : divu_step
// One combinational restoring-division step on a {rem, quotient} pair.
// Rev    : 1.0  initial release
// ============================================================================

module divu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quotient,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quotient_next
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_fits;

    // rem < divisor always holds, so the shifted value is below 2*divisor
    // and a successful difference fits back into WIDTH bits.
    assign w_shift = {rem, quotient[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, divisor};
    assign w_fits  = ~w_diff[WIDTH];

    assign rem_next      = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign quotient_next = {quotient[WIDTH-2:0], w_fits};
endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : muldiv_unit
// Iterative unsigned MULTU/DIVU with HI/LO; MULDIV_FAST_MULT_EN selects a
// single-cycle multiplier for MULTU.
// Rev    : 1.0  initial release
// ============================================================================

module muldiv_unit
    import control_signals::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int               CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    muldiv_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2*WIDTH:0] r_acc;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH:0]   w_mul_upper;
    logic [2*WIDTH:0] w_mul_next;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;

    // Shift-add: multiplier sits in the low half, partial product in the upper.
    assign w_mul_upper = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next  = {1'b0, w_mul_upper, r_acc[WIDTH-1:1]};

    divu_step #(
        .WIDTH (WIDTH)
    ) u_divu_step (
        .rem           (r_acc[2*WIDTH-1:WIDTH]),
        .quotient      (r_acc[WIDTH-1:0]),
        .divisor       (r_b),
        .rem_next      (w_div_rem),
        .quotient_next (w_div_quo)
    );

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] w_fast_prod;
    assign w_fast_prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.op == MD_DIVU) begin
                            // A zero divisor runs a single DIV cycle that writes the fixed result.
                            r_acc   <= {{(WIDTH+1){1'b0}}, bus.a};
                            r_b     <= bus.b;
                            r_cnt   <= (bus.b == '0) ? '0 : c_cnt_last;
                            r_state <= DIV;
                            r_busy  <= 1'b1;
                        end else begin
`ifdef MULDIV_FAST_MULT_EN
                            r_hi   <= w_fast_prod[2*WIDTH-1:WIDTH];
                            r_lo   <= w_fast_prod[WIDTH-1:0];
                            r_done <= 1'b1;
`else
                            r_acc   <= {{(WIDTH+1){1'b0}}, bus.a};
                            r_b     <= bus.b;
                            r_cnt   <= c_cnt_last;
                            r_state <= MUL;
                            r_busy  <= 1'b1;
`endif
                        end
                    end
                end
                MUL: begin
                    r_acc <= w_mul_next;
                    if (r_cnt == '0) begin
                        r_hi    <= w_mul_next[2*WIDTH-1:WIDTH];
                        r_lo    <= w_mul_next[WIDTH-1:0];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                DIV: begin
                    if (r_b == '0) begin
                        r_hi    <= r_acc[WIDTH-1:0];
                        r_lo    <= '1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_acc <= {1'b0, w_div_rem, w_div_quo};
                        if (r_cnt == '0) begin
                            r_hi    <= w_div_rem;
                            r_lo    <= w_div_quo;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - c_cnt_one;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.stall = r_busy & (bus.start | bus.mf_req);
endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_muldiv_unit
// Directed scoreboard bench for muldiv_unit; honours MULDIV_FAST_MULT_EN.
// Rev    : 1.0  initial release
// ============================================================================

module tb_muldiv_unit;
    import global_types::*;
    import control_signals::*;

`ifdef MULDIV_FAST_MULT_EN
    localparam int c_mul_busy = 0;
`else
    localparam int c_mul_busy = 32;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    logic64 sb_q[$];

    task automatic chk(input string tag, input logic64 obs, input logic64 exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic64 model(input muldiv_op_t op, input logic32 a, input logic32 b);
        if (op == MD_MULTU) return {32'd0, a} * {32'd0, b};
        if (b == 32'd0)     return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input muldiv_op_t op, input logic32 a, input logic32 b, input bit push);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        if (push) sb_q.push_back(model(op, a, b));
        tick();
        bus.start = 1'b0;
    endtask

    task automatic check_result(input string tag);
        logic64 e;
        chk({tag, "_sb_nonempty"}, logic64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_hi"}, logic64'(bus.hi), logic64'(e[63:32]));
            chk({tag, "_lo"}, logic64'(bus.lo), logic64'(e[31:0]));
        end
    endtask

    // Called one cycle after the issuing edge; counts busy cycles up to done.
    task automatic wait_done(input string tag, input int exp_busy);
        int     nb      = 0;
        int     guard   = 0;
        bit     hold_ok = 1'b1;
        logic64 held    = {bus.hi, bus.lo};
        while (!bus.done && guard < 100) begin
            if (bus.busy) nb++;
            if ({bus.hi, bus.lo} !== held) hold_ok = 1'b0;
            tick();
            guard++;
        end
        chk({tag, "_done"}, logic64'(bus.done), 64'd1);
        chk({tag, "_busy_cycles"}, logic64'(nb), logic64'(exp_busy));
        chk({tag, "_hilo_held"}, logic64'(hold_ok), 64'd1);
        check_result(tag);
        tick();
        chk({tag, "_done_single"}, logic64'(bus.done), 64'd0);
    endtask

    initial begin
        muldiv_op_t bg_op;
        logic32     bg_a;
        logic32     bg_b;
        int         guard;

        bus.start  = 1'b0;
        bus.op     = MD_MULTU;
        bus.a      = '0;
        bus.b      = '0;
        bus.mf_req = 1'b0;

        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_hi",    logic64'(bus.hi),    64'd0);
        chk("rst_lo",    logic64'(bus.lo),    64'd0);
        chk("rst_busy",  logic64'(bus.busy),  64'd0);
        chk("rst_done",  logic64'(bus.done),  64'd0);
        chk("rst_stall", logic64'(bus.stall), 64'd0);
        rst_n = 1'b1;
        tick();

        start_op(MD_MULTU, 32'd7, 32'd6, 1'b1);
        wait_done("mul_7x6", c_mul_busy);

        start_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("mul_max", c_mul_busy);

        start_op(MD_DIVU, 32'd100, 32'd7, 1'b1);
        wait_done("div_100_7", 32);

        start_op(MD_DIVU, 32'd5, 32'd9, 1'b1);
        wait_done("div_5_9", 32);

        start_op(MD_DIVU, 32'h1234, 32'd0, 1'b1);
        wait_done("div_by_zero", 1);

        // Conflicting issue and MFHI/MFLO arrive mid-operation and are held off.
`ifdef MULDIV_FAST_MULT_EN
        bg_op = MD_DIVU;
        bg_a  = 32'hFFFF_FFFF;
        bg_b  = 32'd3;
`else
        bg_op = MD_MULTU;
        bg_a  = 32'h0001_2345;
        bg_b  = 32'h0000_BEEF;
`endif
        start_op(bg_op, bg_a, bg_b, 1'b1);
        repeat (9) tick();
        bus.op     = MD_DIVU;
        bus.a      = 32'd50;
        bus.b      = 32'd5;
        bus.start  = 1'b1;
        bus.mf_req = 1'b1;
        #1;
        chk("stall_mid", logic64'(bus.stall), 64'd1);
        guard = 0;
        while (bus.busy && guard < 100) begin
            tick();
            guard++;
        end
        chk("stall_busy_fell", logic64'(bus.busy),  64'd0);
        chk("stall_drop",      logic64'(bus.stall), 64'd0);
        chk("stall_bg_done",   logic64'(bus.done),  64'd1);
        check_result("stall_bg");
        // The held DIVU issues in the done cycle with no dead cycle.
        sb_q.push_back(model(MD_DIVU, 32'd50, 32'd5));
        bus.mf_req = 1'b0;
        tick();
        bus.start = 1'b0;
        wait_done("b2b_div", 32);

        start_op(MD_DIVU, 32'd1000, 32'd3, 1'b0);
        repeat (14) tick();
        chk("pre_rst_busy", logic64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi",   logic64'(bus.hi),   64'd0);
        chk("midrst_lo",   logic64'(bus.lo),   64'd0);
        chk("midrst_busy", logic64'(bus.busy), 64'd0);
        tick();
        chk("midrst_done", logic64'(bus.done), 64'd0);
        rst_n = 1'b1;
        guard = 0;
        repeat (40) begin
            tick();
            if (bus.done) guard++;
        end
        chk("postrst_no_done", logic64'(guard), 64'd0);

        start_op(MD_MULTU, 32'd3, 32'd4, 1'b1);
        wait_done("mul_3x4", c_mul_busy);

        chk("sb_drained", logic64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative unsigned multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the control unit in the execute stage. The unit consumes the MULTU/DIVU decode and register operands, and supplies HI/LO to the result mux for MFHI/MFLO. While an operation is in flight, it raises a stall request so the pipeline cannot issue a conflicting instruction.

## Interface
- `WIDTH`, default 32: operand and HI/LO width.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: issue request; qualifies `op`, `a`, `b`.
- `op` input, `muldiv_op_t`: `MD_MULTU` or `MD_DIVU`.
- `a` input, WIDTH bits: rs operand (multiplicand or dividend).
- `b` input, WIDTH bits: rt operand (multiplier or divisor).
- `mf_req` input, 1 bit: MFHI/MFLO is in execute this cycle.
- `hi` output, WIDTH bits: HI register (high product or remainder).
- `lo` output, WIDTH bits: LO register (low product or quotient).
- `busy` output, 1 bit: an operation is in flight.
- `done` output, 1 bit: one-cycle pulse; HI/LO were updated on the preceding edge.
- `stall` output, 1 bit: combinational `busy & (start | mf_req)`.

## Operation
- FSM states are IDLE, MUL, DIV.
- In IDLE, a `start` with `op=MD_MULTU` latches the operands, clears the accumulator, sets the counter to WIDTH-1 and enters MUL.
- In IDLE, a `start` with `op=MD_DIVU` and `b!=0` latches the operands and enters DIV.
- MUL step: if accumulator bit 0 is 1, add `b` to the upper half with a WIDTH+1-bit carry. Then shift the 2*WIDTH+1-bit accumulator right by 1.
- DIV step (restoring): shift {rem, quotient} left by 1 and trial-subtract `b` from the WIDTH+1-bit remainder. If the result is non-negative, commit it and set quotient bit 0 to 1; otherwise restore the remainder and set the bit to 0.
- When the counter reaches 0, the final step writes `hi`/`lo`, pulses `done` and returns to IDLE.
- Divide by zero: `start` with `op=MD_DIVU` and `b==0` enters DIV with a counter of 0. On the next edge `hi=a` and `lo={WIDTH{1'b1}}`, and `done` pulses.
- `start` while `busy` is ignored and no state changes. `stall` holds the issuing instruction in place until `busy` falls.
- `mf_req` while `busy` asserts `stall`. HI/LO are never read mid-operation.
- `hi` and `lo` change only on the completion edge and hold their value otherwise.
- Only unsigned arithmetic is performed; there is no overflow and no exception.

## Timing
- Reset state: state=IDLE, counter=0, accumulator=0, `hi=0`, `lo=0`, `busy=0`, `done=0`. `stall=0` follows from `busy=0`.
- Reset asserted mid-operation abandons the operation immediately; HI/LO are cleared and no `done` pulse occurs.
- Let E0 be the edge that samples `start`.
- Iterative MULTU or DIVU: `busy=1` for the WIDTH cycles after E0. Results are written at E0+WIDTH, so for WIDTH=32 this is E32.
- In the cycle after the completion edge, `busy=0` and `done=1`.
- Divide by zero: `busy=1` for one cycle, the result is written at E1, and `done=1` in the following cycle.
- A new `start` may be accepted in the same cycle that `done=1`, giving back-to-back issue with no dead cycle.

## Configuration
- Macro: `MULDIV_FAST_MULT_EN`.
- Defined: MULTU computes `a*b` with a single-cycle multiplier. HI/LO are written at E0 and `done=1` in the next cycle. `busy` is never asserted for MULTU, and the MUL state is unreachable.
- Undefined: MULTU uses the iterative shift-add path described in Operation.
- DIVU behaviour is identical in both builds.

## Structure
- `control_signals` package holds:
  - the `muldiv_op_t` enum (`MD_MULTU`, `MD_DIVU`);
  - the FSM state enum `muldiv_state_t`.
- `global_types` package supplies the `logic32` and `logic64` typedefs.
- One sub-module, `divu_step`: a combinational single restoring-division step. Inputs are rem, quotient and divisor; outputs are the next rem and quotient. It is instantiated once in DIV.

## Test plan
- MULTU `a=7`, `b=6` → `hi=0`, `lo=42`. `busy` is high for 32 cycles, then `done` pulses once.
- MULTU `a=0xFFFFFFFF`, `b=0xFFFFFFFF` → `hi=0xFFFFFFFE`, `lo=0x00000001`. Repeat with `MULDIV_FAST_MULT_EN` defined and check 1-cycle latency.
- DIVU `a=100`, `b=7` → `lo=14`, `hi=2`. DIVU `a=5`, `b=9` → `lo=0`, `hi=5`.
- DIVU `a=0x1234`, `b=0` → `hi=0x1234`, `lo=0xFFFFFFFF`, with `busy` high for exactly 1 cycle.
- During a MULTU, drive `start` with DIVU and `mf_req=1` at cycle 10 → `stall=1` and the request is ignored. The result still equals the original MULTU, and `stall` drops the cycle `busy` falls.
- Deassert `rst_n` at cycle 15 of a DIVU → `hi=0`, `lo=0`, `busy=0` immediately and no `done` pulse. A fresh MULTU `3*4` afterwards gives `lo=12`.
